ddr2_arbiter: RTL and testbench
===============================

Name: ddr2_arbiter

Overview:
- Shares the single DDR2 memory-controller port between two cache instances: port 0 is the instruction cache, port 1 is the data cache.
- Each port takes the cache's ddr2_* pins directly. Requests are buffered per port, served round-robin one at a time, and read data is routed back to the issuing cache.
- Write acknowledges from DDR2 are absorbed, so a cache waiting for fill data never mistakes a write-back ack for read data.

Parameters:
- ADDR_W, 27, byte address width; matches the cache ddr2_addr width.
- DATA_W, 128, line width.
- FIFO_DEPTH, 2, request entries per port; the value must be a power of two.

Ports:
- clk  in  1  system clock.
- rstn  in  1  synchronous active-low reset.
- p0_enable, p1_enable  in  1  request strobe, one cycle per request; back-to-back strobes are legal.
- p0_read, p1_read  in  1  1 = line read, 0 = line write.
- p0_addr, p1_addr  in  ADDR_W  line address; bits [3:0] are zero.
- p0_wdata, p1_wdata  in  DATA_W  write line.
- p0_available, p1_available  out  1  one-cycle read-data-valid pulse.
- p0_rdata, p1_rdata  out  DATA_W  read line; held until the next read completion on that port.
- p0_overflow, p1_overflow  out  1  sticky: a request arrived while that port's FIFO was full.
- mem_enable  out  1  one-cycle command strobe to DDR2.
- mem_read  out  1  command type.
- mem_addr  out  ADDR_W  command address.
- mem_wdata  out  DATA_W  command write data.
- mem_available  in  1  one-cycle completion pulse for both reads and writes.
- mem_rdata  in  DATA_W  read line; valid when mem_available is high.

Behaviour:
- Reset (rstn low at a clk edge):
  - State goes to IDLE; both FIFOs are emptied; the round-robin pointer selects port 0 first.
  - mem_enable, mem_read, p*_available and p*_overflow go to 0; mem_addr, mem_wdata and p*_rdata go to 0.
  - Reset mid-transaction abandons it. A mem_available arriving after reset, in IDLE, is ignored.
- Capture:
  - A pN_enable high at an edge pushes {read, addr, wdata} into FIFO N.
  - This happens in every state, including the same cycle the arbiter pops that FIFO. Pop and push on the same edge is legal when the FIFO is full.
  - A push to a full FIFO without a simultaneous pop is dropped and sets pN_overflow until reset.
- The state machine is registered; all outputs are registered.
- IDLE:
  - If either FIFO is non-empty, pick a port.
  - With both non-empty, pick the port not granted last. With one non-empty, pick that one.
  - Pop the head entry. Load mem_read, mem_addr and mem_wdata from it; set mem_enable=1 and gnt=port; go to WAIT.
- WAIT:
  - mem_enable=0. mem_addr, mem_read and mem_wdata hold their values.
  - On mem_available: if the command was a read, latch mem_rdata into pgnt_rdata and go to RESP. If it was a write, go to IDLE with no pulse.
  - In both cases, update the last-granted port to gnt.
- RESP: pgnt_available=1 for exactly this cycle; go to IDLE.
- Latency:
  - The earliest mem_enable is 1 cycle after the edge that captured the request. An empty FIFO is not bypassed.
  - mem_available at edge u produces pN_available high during the cycle after u.
- Ordering:
  - Requests from one port are issued in arrival order. A write-back followed immediately by a refill read is issued write first.
  - At most one DDR2 command is outstanding. A mem_available outside WAIT is ignored.
- Fairness: under continuous contention the grants alternate 0,1,0,1.

Test Plan:
- Reset, then p0 read pulse addr=0x0000120, then mem_available 5 cycles after mem_enable with rdata=128'hA5…A5 -> mem_enable 1 cycle after capture with mem_addr=0x0000120 and mem_read=1; p0_available pulses once with p0_rdata=A5…A5; p1_available stays 0.
- p1 write addr=0x0004560 wdata=W on cycle t, then p1 read addr=0x0000560 on t+1 -> write issued first; its ack produces no p1_available; the read is issued next and is then acknowledged with a single p1_available pulse.
- p0 read and p1 read on the same cycle, twice in a row -> mem_enable grant order 0,1,0,1; each rdata lands on the correct port.
- Three back-to-back p0 requests while a p1 transaction is outstanding in WAIT -> third request dropped and p0_overflow=1; the first two complete in order.
- rstn low for one cycle while in WAIT, then a late mem_available -> no pN_available pulse, FIFOs empty, mem_enable stays 0 until a new request.

Source files
------------

// File: rtl/ddr2_arbiter.sv
// Two-port DDR2 command arbiter: per-port request FIFOs, round-robin issue,
// one outstanding command, read data steered back to the issuing cache.
module ddr2_arbiter #(
    parameter int ADDR_W     = 27,
    parameter int DATA_W     = 128,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              p0_enable,
    input  logic              p0_read,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_available,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_overflow,
    input  logic              p1_enable,
    input  logic              p1_read,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_available,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_overflow,
    output logic              mem_enable,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_available,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state_q, state_d;

    logic [1:0]        in_en, in_read;
    logic [ADDR_W-1:0] in_addr  [2];
    logic [DATA_W-1:0] in_wdata [2];

    logic [FIFO_DEPTH-1:0] fifo_read  [2];
    logic [ADDR_W-1:0]     fifo_addr  [2][FIFO_DEPTH];
    logic [DATA_W-1:0]     fifo_wdata [2][FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr [2];
    logic [PTR_W-1:0]      rd_ptr [2];
    logic [PTR_W:0]        count  [2];

    logic [1:0]        empty, full, push, pop, avail_q, overflow_q;
    logic [DATA_W-1:0] rdata_q [2];
    logic              sel, issue, last_gnt, gnt;

    assign in_en       = {p1_enable, p0_enable};
    assign in_read     = {p1_read, p0_read};
    assign in_addr[0]  = p0_addr;
    assign in_addr[1]  = p1_addr;
    assign in_wdata[0] = p0_wdata;
    assign in_wdata[1] = p1_wdata;

    assign p0_available = avail_q[0];
    assign p1_available = avail_q[1];
    assign p0_rdata     = rdata_q[0];
    assign p1_rdata     = rdata_q[1];
    assign p0_overflow  = overflow_q[0];
    assign p1_overflow  = overflow_q[1];

    // A full FIFO still accepts a push when its head is popped on the same edge.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            empty[p] = (count[p] == '0);
            full[p]  = (count[p] == (PTR_W+1)'(FIFO_DEPTH));
            push[p]  = in_en[p] && (!full[p] || pop[p]);
        end
    end

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        if (empty[0])
            sel = 1'b1;
        else if (empty[1])
            sel = 1'b0;
        else
            sel = ~last_gnt;
        case (state_q)
            IDLE: begin
                if (empty != 2'b11) begin
                    issue   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_available)
                    state_d = mem_read ? RESP : IDLE;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        pop = issue ? (2'b01 << sel) : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int p = 0; p < 2; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
                count[p]  <= '0;
            end
            overflow_q <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (push[p])
                    wr_ptr[p] <= wr_ptr[p] + PTR_W'(1);
                if (pop[p])
                    rd_ptr[p] <= rd_ptr[p] + PTR_W'(1);
                case ({push[p], pop[p]})
                    2'b10:   count[p] <= count[p] + (PTR_W+1)'(1);
                    2'b01:   count[p] <= count[p] - (PTR_W+1)'(1);
                    default: ;
                endcase
                if (in_en[p] && full[p] && !pop[p])
                    overflow_q[p] <= 1'b1;
            end
        end
    end

    // Entry storage needs no reset: occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (push[p]) begin
                fifo_read[p][wr_ptr[p]]  <= in_read[p];
                fifo_addr[p][wr_ptr[p]]  <= in_addr[p];
                fifo_wdata[p][wr_ptr[p]] <= in_wdata[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            last_gnt   <= 1'b1;
            gnt        <= 1'b0;
            mem_enable <= 1'b0;
            mem_read   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            avail_q    <= '0;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
        end else begin
            state_q    <= state_d;
            mem_enable <= issue;
            avail_q    <= '0;
            if (issue) begin
                gnt       <= sel;
                mem_read  <= fifo_read[sel][rd_ptr[sel]];
                mem_addr  <= fifo_addr[sel][rd_ptr[sel]];
                mem_wdata <= fifo_wdata[sel][rd_ptr[sel]];
            end
            // Write acks end the transaction silently; only reads reach the cache.
            if (state_q == WAIT && mem_available) begin
                last_gnt <= gnt;
                if (mem_read) begin
                    rdata_q[gnt] <= mem_rdata;
                    avail_q[gnt] <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ddr2_arbiter.sv
// Directed bench for ddr2_arbiter: a queue-based transaction model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_ddr2_arbiter;
    localparam int AW = 27;
    localparam int DW = 128;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic p0_enable = 1'b0, p0_read = 1'b0, p1_enable = 1'b0, p1_read = 1'b0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
    logic p0_available, p1_available, p0_overflow, p1_overflow;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic mem_enable, mem_read;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic mem_available = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    ddr2_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .p0_enable(p0_enable), .p0_read(p0_read), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_available(p0_available), .p0_rdata(p0_rdata), .p0_overflow(p0_overflow),
        .p1_enable(p1_enable), .p1_read(p1_read), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_available(p1_available), .p1_rdata(p1_rdata), .p1_overflow(p1_overflow),
        .mem_enable(mem_enable), .mem_read(mem_read), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_available(mem_available), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction model ----------------
    typedef struct packed {
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
    } req_t;

    req_t    mq[2][$];
    req_t    r;
    bit      started = 0;
    bit      m_busy, m_resp, m_last, m_port, was_busy, was_resp;
    bit      m_en, m_rd;
    bit [1:0] m_av, m_ovf;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd;
    logic [DW-1:0] m_rdata[2];

    always @(posedge clk) begin
        if (!rstn) begin
            started = 1;
            mq[0].delete();
            mq[1].delete();
            m_busy = 0; m_resp = 0; m_last = 1; m_port = 0;
            m_en = 0; m_rd = 0; m_av = 0; m_ovf = 0;
            m_addr = '0; m_wd = '0; m_rdata[0] = '0; m_rdata[1] = '0;
        end else begin
            was_busy = m_busy;
            was_resp = m_resp;
            m_resp = 0; m_en = 0; m_av = 0;
            if (!was_busy && !was_resp && (mq[0].size() + mq[1].size()) > 0) begin
                if (mq[0].size() == 0) m_port = 1;
                else if (mq[1].size() == 0) m_port = 0;
                else m_port = !m_last;
                r = mq[m_port].pop_front();
                m_rd = r.rd; m_addr = r.addr; m_wd = r.wd;
                m_en = 1; m_busy = 1;
            end else if (was_busy && mem_available) begin
                m_busy = 0;
                m_last = m_port;
                if (m_rd) begin
                    m_av[m_port] = 1;
                    m_rdata[m_port] = mem_rdata;
                    m_resp = 1;
                end
            end
            if (p0_enable) begin
                if (mq[0].size() < DEPTH) mq[0].push_back({p0_read, p0_addr, p0_wdata});
                else m_ovf[0] = 1;
            end
            if (p1_enable) begin
                if (mq[1].size() < DEPTH) mq[1].push_back({p1_read, p1_addr, p1_wdata});
                else m_ovf[1] = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("mdl_mem_enable", DW'(mem_enable), DW'(m_en));
            chk("mdl_mem_read", DW'(mem_read), DW'(m_rd));
            chk("mdl_mem_addr", DW'(mem_addr), DW'(m_addr));
            chk("mdl_mem_wdata", mem_wdata, m_wd);
            chk("mdl_p0_available", DW'(p0_available), DW'(m_av[0]));
            chk("mdl_p1_available", DW'(p1_available), DW'(m_av[1]));
            chk("mdl_p0_rdata", p0_rdata, m_rdata[0]);
            chk("mdl_p1_rdata", p1_rdata, m_rdata[1]);
            chk("mdl_p0_overflow", DW'(p0_overflow), DW'(m_ovf[0]));
            chk("mdl_p1_overflow", DW'(p1_overflow), DW'(m_ovf[1]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        if (p == 0) begin
            p0_enable = 1'b1; p0_read = rd; p0_addr = a; p0_wdata = wd;
        end else begin
            p1_enable = 1'b1; p1_read = rd; p1_addr = a; p1_wdata = wd;
        end
    endtask

    task automatic clr_req();
        p0_enable = 1'b0; p1_enable = 1'b0;
    endtask

    task automatic wait_cmd(input string name, input logic [AW-1:0] a, input logic rd);
        int n;
        n = 0;
        while (mem_enable !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        chk({name, "_issued"}, DW'(mem_enable), DW'(1'b1));
        chk({name, "_addr"}, DW'(mem_addr), DW'(a));
        chk({name, "_read"}, DW'(mem_read), DW'(rd));
    endtask

    task automatic mem_ack(input logic [DW-1:0] d);
        mem_available = 1'b1;
        mem_rdata = d;
        tick();
        mem_available = 1'b0;
        mem_rdata = '0;
    endtask

    localparam logic [DW-1:0] A5 = {16{8'hA5}};
    localparam logic [DW-1:0] WLINE = {4{32'hDEADBEEF}};
    localparam logic [DW-1:0] D2 = {8{16'h5A5A}};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Reset
        rstn = 1'b0;
        repeat (3) tick();
        chk("rst_mem_enable", DW'(mem_enable), '0);
        chk("rst_mem_addr", DW'(mem_addr), '0);
        chk("rst_p0_rdata", p0_rdata, '0);
        chk("rst_overflow", DW'({p1_overflow, p0_overflow}), '0);
        rstn = 1'b1;
        tick();

        // Single p0 read, latency and data return
        set_req(0, 1'b1, 27'h0000120, '0);
        tick();
        clr_req();
        chk("t1_no_bypass", DW'(mem_enable), '0);
        tick();
        chk("t1_enable", DW'(mem_enable), DW'(1'b1));
        chk("t1_addr", DW'(mem_addr), DW'(27'h0000120));
        chk("t1_read", DW'(mem_read), DW'(1'b1));
        repeat (4) tick();
        mem_ack(A5);
        chk("t1_p0_avail", DW'(p0_available), DW'(1'b1));
        chk("t1_p0_rdata", p0_rdata, A5);
        chk("t1_p1_avail", DW'(p1_available), '0);
        tick();
        chk("t1_p0_avail_drop", DW'(p0_available), '0);

        // Write-back then refill on p1
        set_req(1, 1'b0, 27'h0004560, WLINE);
        tick();
        set_req(1, 1'b1, 27'h0000560, '0);
        tick();
        clr_req();
        wait_cmd("t2_wr", 27'h0004560, 1'b0);
        chk("t2_wdata", mem_wdata, WLINE);
        repeat (2) tick();
        mem_ack({DW{1'b1}});
        chk("t2_wr_no_avail", DW'(p1_available), '0);
        wait_cmd("t2_rd", 27'h0000560, 1'b1);
        repeat (3) tick();
        mem_ack(D2);
        chk("t2_rd_avail", DW'(p1_available), DW'(1'b1));
        chk("t2_rd_data", p1_rdata, D2);
        tick();

        // Contention: grants alternate 0,1,0,1
        set_req(0, 1'b1, 27'h0001000, '0);
        set_req(1, 1'b1, 27'h0002000, '0);
        tick();
        set_req(0, 1'b1, 27'h0001010, '0);
        set_req(1, 1'b1, 27'h0002010, '0);
        tick();
        clr_req();
        wait_cmd("t3_g0", 27'h0001000, 1'b1);
        tick();
        mem_ack({8{16'h1000}});
        chk("t3_g0_port", DW'({p1_available, p0_available}), DW'(2'b01));
        wait_cmd("t3_g1", 27'h0002000, 1'b1);
        tick();
        mem_ack({8{16'h2000}});
        chk("t3_g1_port", DW'({p1_available, p0_available}), DW'(2'b10));
        wait_cmd("t3_g2", 27'h0001010, 1'b1);
        tick();
        mem_ack({8{16'h1010}});
        chk("t3_g2_data", p0_rdata, {8{16'h1010}});
        wait_cmd("t3_g3", 27'h0002010, 1'b1);
        tick();
        mem_ack({8{16'h2010}});
        chk("t3_g3_data", p1_rdata, {8{16'h2010}});
        chk("t3_p0_kept", p0_rdata, {8{16'h1010}});
        tick();

        // Overflow while p1 is outstanding
        set_req(1, 1'b1, 27'h0003000, '0);
        tick();
        clr_req();
        wait_cmd("t4_p1", 27'h0003000, 1'b1);
        set_req(0, 1'b1, 27'h0001100, '0);
        tick();
        set_req(0, 1'b1, 27'h0001110, '0);
        tick();
        chk("t4_no_ovf_yet", DW'(p0_overflow), '0);
        set_req(0, 1'b1, 27'h0001120, '0);
        tick();
        clr_req();
        chk("t4_ovf", DW'(p0_overflow), DW'(1'b1));
        mem_ack({8{16'h3000}});
        chk("t4_p1_avail", DW'(p1_available), DW'(1'b1));
        wait_cmd("t4_a", 27'h0001100, 1'b1);
        mem_ack({8{16'h1100}});
        wait_cmd("t4_b", 27'h0001110, 1'b1);
        mem_ack({8{16'h1110}});
        chk("t4_b_data", p0_rdata, {8{16'h1110}});
        repeat (4) begin
            tick();
            chk("t4_no_third", DW'(mem_enable), '0);
        end

        // Reset during WAIT, then a late ack
        set_req(0, 1'b1, 27'h0007000, '0);
        tick();
        clr_req();
        wait_cmd("t5_pre", 27'h0007000, 1'b1);
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        mem_available = 1'b1;
        mem_rdata = A5;
        tick();
        mem_available = 1'b0;
        mem_rdata = '0;
        chk("t5_ovf_cleared", DW'(p0_overflow), '0);
        repeat (3) begin
            tick();
            chk("t5_no_avail", DW'({p1_available, p0_available}), '0);
            chk("t5_idle", DW'(mem_enable), '0);
        end
        set_req(1, 1'b1, 27'h0007100, '0);
        tick();
        clr_req();
        wait_cmd("t5_post", 27'h0007100, 1'b1);
        mem_ack(D2);
        chk("t5_post_avail", DW'(p1_available), DW'(1'b1));
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
